// File: rtl/rs232_avs_uart_if.sv
// Avalon-MM slave bus bundle for the RS232 UART register block.
interface rs232_avs_uart_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output avs_waitrequest
    );

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  avs_waitrequest
    );
endinterface

// File: rtl/rs232_avs_uart.sv
// Avalon-MM UART: RX data at 0, TX data at 4, status at 8; 8N1 framing on uart_rxd/uart_txd.
module rs232_avs_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic            avm_clk,
    input  logic            avm_rst,
    rs232_avs_uart_if.slave avs,
    input  logic            uart_rxd,
    output logic            uart_txd
);
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TIdle, TStart, TData, TStop} tx_state_e;
    typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic        ack_q, ack_d;
    logic [31:0] readdata_q, readdata_d;
    logic        rrdy_q, rrdy_d, trdy_q, trdy_d;
    logic        toe_q, toe_d, roe_q, roe_d, fe_q, fe_d;
    logic [7:0]  hold_q, hold_d, tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic        txd_q, txd_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;

    logic       req, rd_done, wr_done, sel_rx, sel_tx, sel_st;
    logic [7:0] status;
    logic       unused_wdata;

    assign req                 = avs.avs_read | avs.avs_write;
    assign avs.avs_waitrequest = req & ~ack_q;
    assign avs.avs_readdata    = readdata_q;
    assign uart_txd            = txd_q;
    assign sel_rx              = (avs.avs_address == 5'd0);
    assign sel_tx              = (avs.avs_address == 5'd4);
    assign sel_st              = (avs.avs_address == 5'd8);
    assign rd_done             = ack_q & avs.avs_read;
    assign wr_done             = ack_q & avs.avs_write & ~avs.avs_read;
    assign status              = {rrdy_q, trdy_q, 1'b0, toe_q, roe_q, fe_q, 2'b00};
    assign unused_wdata        = ^avs.avs_writedata[31:8];

    always_comb begin
        ack_d      = req & ~ack_q;
        readdata_d = readdata_q;
        if (avs.avs_read && !ack_q) begin
            if (sel_st)      readdata_d = {24'b0, status};
            else if (sel_rx) readdata_d = {24'b0, rx_data_q};
            else             readdata_d = '0;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        hold_d     = hold_q;
        trdy_d     = trdy_q;
        toe_d      = toe_q;
        roe_d      = roe_q;
        fe_d       = fe_q;
        rrdy_d     = rrdy_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;

        // Bus clears come first so that same-cycle flag sets below win.
        if (wr_done && sel_st) begin
            toe_d = 1'b0;
            roe_d = 1'b0;
            fe_d  = 1'b0;
        end
        if (rd_done && sel_rx) rrdy_d = 1'b0;
        if (wr_done && sel_tx) begin
            if (trdy_q) begin
                hold_d = avs.avs_writedata[7:0];
                trdy_d = 1'b0;
            end else begin
                toe_d = 1'b1;
            end
        end

        unique case (tx_state_q)
            TIdle: begin
                if (!trdy_q) begin
                    tx_shift_d = hold_q;
                    trdy_d     = 1'b1;
                    txd_d      = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TStart;
                end
            end
            TStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = TData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TStop;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                        tx_idx_d   = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!trdy_q) begin
                        tx_shift_d = hold_q;
                        trdy_d     = 1'b1;
                        txd_d      = 1'b0;
                        tx_state_d = TStart;
                    end else begin
                        tx_state_d = TIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TIdle;
        endcase

        unique case (rx_state_q)
            RIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RStart;
                end
            end
            RStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_state_d = rx_s2_q ? RIdle : RData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) rx_state_d = RStop;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RIdle;
                    if (rx_s2_q) begin
                        rx_data_d = rx_shift_q;
                        rrdy_d    = 1'b1;
                        // A byte read out in this same cycle is not an overrun.
                        if (rrdy_q && !(rd_done && sel_rx)) roe_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RIdle;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            ack_q      <= 1'b0;
            readdata_q <= '0;
            rrdy_q     <= 1'b0;
            trdy_q     <= 1'b1;
            toe_q      <= 1'b0;
            roe_q      <= 1'b0;
            fe_q       <= 1'b0;
            hold_q     <= '0;
            tx_state_q <= TIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= RIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            readdata_q <= readdata_d;
            rrdy_q     <= rrdy_d;
            trdy_q     <= trdy_d;
            toe_q      <= toe_d;
            roe_q      <= roe_d;
            fe_q       <= fe_d;
            hold_q     <= hold_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end
endmodule

// File: doc/rs232_avs_uart.md
# rs232_avs_uart

Avalon-MM slave UART implementing the RS232 register map our host-side wrappers poll: RX data at byte address 0, TX data at 4, status at 8, with RX-ready at status bit 7 and TX-ready at bit 6. It is the responder end of the wrapper's read/write protocol. It serializes TX bytes and deserializes RX bytes as 8N1 frames. It serves as both a synthesizable UART and the bench responder for wrapper-level simulation.

## Interface
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535
- avm_clk  in  1  clock; all logic on rising edge
- avm_rst  in  1  reset; synchronous and active-high
- avs_address  in  5  byte address (0 RX, 4 TX, 8 STATUS; others unmapped)
- avs_read  in  1  read request, held until accepted
- avs_readdata  out  32  read data, valid in the completion cycle
- avs_write  in  1  write request, held until accepted
- avs_writedata  out/in  32  input; write data, only [7:0] used
- avs_waitrequest  out  1  high while the access is stalled
- uart_rxd  in  1  serial input, asynchronous, idle high
- uart_txd  out  1  serial output, idle high

## Operation
- Handshake: req = avs_read | avs_write. avs_waitrequest = req & ~ack_r (combinational). ack_r <= req & ~ack_r. Every access takes exactly 2 cycles: a wait cycle, then a completion cycle. A request held continuously completes every second cycle. Side effects take place at the end of the completion cycle.
- If read and write are asserted together, the read is served and the write is ignored.
- readdata_r is loaded at the end of the wait cycle, holds its value otherwise, and is 0 at reset.
  - STATUS reads return {24'b0, RRDY, TRDY, 1'b0, TOE, ROE, FE, 2'b0}, so RRDY = bit7, TRDY = bit6, TOE = bit4, ROE = bit3, FE = bit2.
  - RX reads return {24'b0, rx_data}.
  - TX and unmapped reads return 0.
- RX read completion clears RRDY. STATUS write completion clears TOE, ROE and FE. Unmapped writes are ignored.
- TX write completion:
  - If TRDY = 1, writedata[7:0] is loaded into the holding register and TRDY goes to 0.
  - Otherwise the data is dropped and TOE is set.
- TX FSM (T_IDLE, T_START, T_DATA, T_STOP):
  - In T_IDLE with the holding register full: load the shifter, set TRDY = 1, drive uart_txd = 0, enter T_START.
  - Each bit lasts CLKS_PER_BIT cycles. Data is sent LSB first (8 bits), then a stop bit of 1.
  - From T_STOP, return to T_IDLE. If the holding register is full, the next start bit follows without a gap.
- RX FSM (R_IDLE, R_START, R_DATA, R_STOP):
  - uart_rxd passes through a 2-flop synchronizer. A falling edge of the synchronized line moves R_IDLE to R_START.
  - At CLKS_PER_BIT/2 the line is resampled. If high, it is a false start: return to R_IDLE with no flags. If low, enter R_DATA.
  - In R_DATA, 8 bits are sampled every CLKS_PER_BIT, LSB first.
  - In R_STOP, the stop bit is sampled. If high: rx_data <= byte and RRDY <= 1; if RRDY was already 1, the old byte is overwritten and ROE is set. If low: FE is set and the byte is discarded.
  - Either way, return to R_IDLE. A new frame needs a fresh high-to-low edge.
- Counters: bit timer is 16 bits and wraps to 0 at CLKS_PER_BIT-1; bit index is 3 bits.

## Timing
- Reset values:
  - uart_txd = 1, avs_waitrequest = 0 when idle, avs_readdata = 0.
  - RRDY = 0, TRDY = 1, all error flags 0.
  - Both FSMs in IDLE, ack_r = 0, holding register empty.
- Reset mid-frame aborts both frames; uart_txd is 1 from the first cycle after reset.
- TX latency, with the write completing in cycle C:
  - Holding register full after edge C+1.
  - Shifter loads and uart_txd falls after edge C+2; TRDY = 1 again from that edge.
  - Frame length is 10*CLKS_PER_BIT cycles.
- RX latency: RRDY rises about 2 synchronizer cycles plus 9.5*CLKS_PER_BIT after the start-bit falling edge.
- Simultaneous events:
  - An RX read completing in the same cycle as a new byte commit: the commit wins, RRDY stays 1, rx_data holds the new byte, ROE is not set.
  - A STATUS-write clear in the same cycle as a flag set: the set wins.
  - A TX write completing in the same cycle TX_IDLE empties the holding register: the write sees the pre-edge TRDY value.

## Test plan
- Reset, then hold a read at address 8: waitrequest toggles 1,0,1,0; each completion returns 0x40; uart_txd stays 1.
- CLKS_PER_BIT=4, drive frame 0xA5 on uart_rxd: STATUS reads 0xC0, RX read returns 0xA5, next STATUS read 0x40.
- Write 0x3C to address 4: uart_txd emits 0,0,0,1,1,1,1,0,0,1, each held 4 cycles, starting 2 edges after completion; TRDY is 1 after load.
- Two RX frames (0x11 then 0x22) without reading: STATUS reads 0xC8, RX read returns 0x22; write address 8 and STATUS reads 0x40.
- RX frame with stop bit 0: STATUS reads 0x44, RRDY 0; a 1-cycle low glitch on uart_rxd sets no flags and RRDY stays 0.
- Two back-to-back TX writes plus a third while the holding register is full: the first two frames go out gap-free, the third byte is dropped, STATUS bit4 = 1; asserting avm_rst mid-frame forces uart_txd = 1 on the next cycle.
